display_multi_digit: RTL and testbench
======================================

Name: display_multi_digit

Overview:
- Parametrised successor to the four-digit seven-segment scanner.
- Time-multiplexes NUM_DIGITS hex digits onto one shared segment bus plus decimal point.
- Adds frame-synchronous value update, leading-zero blanking, inter-digit dead time (anti-ghosting) and blinking.
- Sits between the datapath result registers and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- REFRESH_BITS, 14: each digit slot lasts 2^REFRESH_BITS clk cycles.
- DEAD_CYCLES, 64: cycles at the start of each slot with all anodes inactive. Must be < 2^REFRESH_BITS.
- BLINK_BITS, 23: width of the blink counter. Its MSB is the blink phase.

Ports:
- clk  in  1  system clock (12 MHz on board).
- reset_n  in  1  asynchronous, active-low reset.
- start_signal  in  1  pulse: BLANK->SHOW, or force shadow reload while in SHOW.
- stop_signal  in  1  pulse: SHOW->BLANK.
- input_value  in  4*NUM_DIGITS  nibble i drives digit i; digit 0 is the rightmost.
- dp_in  in  NUM_DIGITS  per-digit decimal point, 1 = lit.
- lz_blank  in  1  enables leading-zero blanking.
- blink_en  in  1  enables whole-display blinking.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}; seg[0] = a.
- dp  out  1  active-low decimal point.
- digits  out  NUM_DIGITS  active-low one-hot anode select; bit i = digit i.
- busy  out  1  1 while in SHOW.

Behaviour:
- Reset (reset_n=0, asynchronous, also mid-scan) forces all of the following immediately:
  - digits = all 1s, seg = 7'h7F, dp = 1, busy = 0.
  - State = BLANK; prescaler, digit index, blink counter and shadow register = 0.
- States: BLANK, SHOW.
  - BLANK: scan counters run; digits held all 1s; seg = 7'h7F.
  - BLANK -> SHOW on start_signal. Shadow register <= input_value on the same edge.
  - SHOW -> BLANK on stop_signal.
  - start_signal and stop_signal asserted in the same cycle: stop wins.
  - start_signal while in SHOW: shadow register reloads; scan position is not reset.
- Prescaler: counts 0..2^REFRESH_BITS-1 and wraps.
  - At terminal count, the digit index increments; NUM_DIGITS-1 wraps to 0.
- Frame-synchronous update: in SHOW, the shadow register <= input_value on the edge where the index wraps to 0.
  - input_value changes mid-frame never tear the display.
  - input_value changes appear from the next frame.
- Anode output: the active digit's anode is driven low only when all of these hold:
  - state = SHOW;
  - prescaler >= DEAD_CYCLES;
  - the digit is not leading-blanked;
  - not (blink_en and blink MSB = 1).
- Leading-zero blanking: digit i > 0 is blanked when lz_blank = 1 and shadow nibbles i..NUM_DIGITS-1 are all 0. Digit 0 is never blanked.
- Blink counter: free-runs only in SHOW and clears on entry to SHOW.
- Decoder (hex, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110
- dp = ~dp_in[index] whenever the anode is active; otherwise 1.
- Latency: seg, dp and digits are registered, so they reflect the index/prescaler value one cycle later.
- When an anode is inactive, seg = 7'h7F (no ghost data on the bus).

Test Plan (REFRESH_BITS=4, DEAD_CYCLES=2, BLINK_BITS=8, NUM_DIGITS=4):
- Reset asserted mid-scan in SHOW -> digits=4'b1111, seg=7'h7F, dp=1, busy=0 within the same cycle; BLANK afterwards until start_signal.
- input_value=16'hABCD, start pulse -> busy=1, then in order:
  - digits=1110 with seg=0100001 (d);
  - digits=1101 with seg=1000110 (C);
  - digits=1011 with seg=0000011 (b);
  - digits=0111 with seg=0001000 (A);
  - first 2 cycles of each 16-cycle slot have digits=1111.
- Change input_value to 16'h1234 while digit 1 is active -> digits 2 and 3 still show b and A in that frame; 4, 3, 2, 1 appear from the next frame.
- lz_blank=1, input_value=16'h0040 -> only digits 0 and 1 ever go low, showing 0 and 4; digits 2 and 3 stay 1. input_value=0 -> only digit 0 lit, showing 0.
- blink_en=1 -> anodes all 1s while blink MSB=1 (128-cycle windows); the dp_in[2]=1 digit shows dp=0 only while active.
- start_signal and stop_signal in the same cycle while in SHOW -> BLANK, busy=0; start alone while in SHOW -> shadow reloaded and scan index unchanged.

Source files
------------

// File: rtl/display_multi_digit.sv
// Time-multiplexed hex driver for NUM_DIGITS common-anode seven-segment digits:
// frame-synchronous value capture, leading-zero blanking, dead time and blinking.
module display_multi_digit #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_BITS = 14,
    parameter int DEAD_CYCLES  = 64,
    parameter int BLINK_BITS   = 23
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start_signal,
    input  logic                    stop_signal,
    input  logic [4*NUM_DIGITS-1:0] input_value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
    input  logic                    blink_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digits,
    output logic                    busy
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [REFRESH_BITS-1:0] PRE_LAST  = {REFRESH_BITS{1'b1}};
    localparam logic [REFRESH_BITS-1:0] PRE_ONE   = {{(REFRESH_BITS-1){1'b0}}, 1'b1};
    localparam logic [REFRESH_BITS-1:0] DEAD_END  = REFRESH_BITS'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]        IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]        IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [BLINK_BITS-1:0]   BLINK_ONE = {{(BLINK_BITS-1){1'b0}}, 1'b1};
    localparam logic [NUM_DIGITS-1:0]   ANODE_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t                  state_q,  state_d;
    logic [REFRESH_BITS-1:0] pre_q,    pre_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic [BLINK_BITS-1:0]   blink_q,  blink_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [6:0]              seg_q,    seg_d;
    logic                    dp_q,     dp_d;
    logic [NUM_DIGITS-1:0]   digits_q, digits_d;
    logic                    busy_q,   busy_d;

    logic                    pre_tc_s;
    logic                    frame_end_s;
    logic                    anode_on_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic [3:0]              nibble_s;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            4'hF:    hex_to_seg = 7'b0001110;
            default: hex_to_seg = 7'b1111111;
        endcase
    endfunction

    // Digit i is blanked while it and every more-significant nibble are zero
    always_comb begin
        logic seen_nonzero;
        seen_nonzero = 1'b0;
        lz_mask_s    = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            seen_nonzero = seen_nonzero | (|shadow_q[4*i +: 4]);
            lz_mask_s[i] = lz_blank & ~seen_nonzero;
        end
    end

    // Scan counters, state transitions and shadow/blink next-state
    always_comb begin
        pre_tc_s    = (pre_q == PRE_LAST);
        frame_end_s = pre_tc_s && (idx_q == IDX_LAST);
        pre_d       = pre_q + PRE_ONE;

        if (pre_tc_s) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_ONE;
            end
        end else begin
            idx_d = idx_q;
        end

        state_d  = state_q;
        shadow_d = shadow_q;
        blink_d  = blink_q;
        case (state_q)
            BLANK: begin
                // stop has priority over a simultaneous start
                if (start_signal && !stop_signal) begin
                    state_d  = SHOW;
                    shadow_d = input_value;
                    blink_d  = '0;
                end else begin
                    state_d  = BLANK;
                end
            end
            SHOW: begin
                blink_d = blink_q + BLINK_ONE;
                if (start_signal || frame_end_s) begin
                    shadow_d = input_value;
                end else begin
                    shadow_d = shadow_q;
                end
                if (stop_signal) begin
                    state_d = BLANK;
                end else begin
                    state_d = SHOW;
                end
            end
            default: state_d = BLANK;
        endcase
        busy_d = (state_d == SHOW);
    end

    // Output decode from the current scan position; registered one cycle later
    always_comb begin
        nibble_s   = shadow_q[{idx_q, 2'b00} +: 4];
        anode_on_s = (state_q == SHOW) && (pre_q >= DEAD_END) && !lz_mask_s[idx_q]
                     && !(blink_en && blink_q[BLINK_BITS-1]);
        if (anode_on_s) begin
            digits_d = ~(ANODE_ONE << idx_q);
            seg_d    = hex_to_seg(nibble_s);
            dp_d     = ~dp_in[idx_q];
        end else begin
            digits_d = {NUM_DIGITS{1'b1}};
            seg_d    = 7'h7F;
            dp_d     = 1'b1;
        end
    end

    // State, counters and registered display outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= BLANK;
            pre_q    <= '0;
            idx_q    <= '0;
            blink_q  <= '0;
            shadow_q <= '0;
            seg_q    <= 7'h7F;
            dp_q     <= 1'b1;
            digits_q <= {NUM_DIGITS{1'b1}};
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            blink_q  <= blink_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            digits_q <= digits_d;
            busy_q   <= busy_d;
        end
    end

    assign seg    = seg_q;
    assign dp     = dp_q;
    assign digits = digits_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_display_multi_digit.sv
// Bench for display_multi_digit: cycle model built from absolute cycle counts
// (slot = cycle/16, position = cycle%16) compared against the DUT every cycle.
module tb_display_multi_digit;

    localparam int N    = 4;
    localparam int RB   = 4;
    localparam int DC   = 2;
    localparam int BB   = 8;
    localparam int SLOT = 1 << RB;
    localparam int HALF_BLINK = 1 << (BB - 1);
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start_signal = 1'b0;
    logic           stop_signal = 1'b0;
    logic [4*N-1:0] input_value = '0;
    logic [N-1:0]   dp_in = '0;
    logic           lz_blank = 1'b0;
    logic           blink_en = 1'b0;
    logic [6:0]     seg;
    logic           dp;
    logic [N-1:0]   digits;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    int             m_cyc;
    bit             m_show;
    logic [4*N-1:0] m_shadow;
    int             m_blink;
    logic [6:0]     exp_seg;
    logic           exp_dp;
    logic [N-1:0]   exp_digits;
    logic           exp_busy;

    display_multi_digit #(
        .NUM_DIGITS(N), .REFRESH_BITS(RB), .DEAD_CYCLES(DC), .BLINK_BITS(BB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_signal(start_signal),
        .stop_signal(stop_signal), .input_value(input_value), .dp_in(dp_in),
        .lz_blank(lz_blank), .blink_en(blink_en), .seg(seg), .dp(dp),
        .digits(digits), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cyc = 0; m_show = 0; m_shadow = '0; m_blink = 0;
        exp_digits = '1; exp_seg = 7'h7F; exp_dp = 1'b1; exp_busy = 1'b0;
    endtask

    // Advance one clock: derive expected outputs from the pre-edge model, then update it
    task automatic tick();
        int  pos, slot;
        bit  lit, frame_end;
        pos  = m_cyc % SLOT;
        slot = (m_cyc / SLOT) % N;
        lit  = m_show && (pos >= DC)
               && !(lz_blank && slot > 0 && (m_shadow >> (4*slot)) == 0)
               && !(blink_en && ((m_blink / HALF_BLINK) % 2 == 1));
        exp_digits = lit ? ~(N'(1) << slot) : '1;
        exp_seg    = lit ? SEG_TAB[m_shadow[4*slot +: 4]] : 7'h7F;
        exp_dp     = lit ? ~dp_in[slot] : 1'b1;
        frame_end  = (pos == SLOT - 1) && (slot == N - 1);
        if (m_show) begin
            m_blink++;
            if (start_signal || frame_end) m_shadow = input_value;
            if (stop_signal) m_show = 0;
        end else if (start_signal && !stop_signal) begin
            m_show = 1; m_blink = 0; m_shadow = input_value;
        end
        exp_busy = m_show;
        m_cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({digits, seg, dp, busy} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_idle: digits=%b seg=%b dp=%b busy=%b, want 1111 1111111 1 0",
                     digits, seg, dp, busy);
        end
        @(negedge clk);
        model_reset();
        reset_n = 1'b1;
        repeat (20) begin
            tick();
            n_checks++;
            if ({digits, seg, dp, busy} !== {exp_digits, exp_seg, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL post_reset cyc=%0d: got %b %b %b %b want %b %b %b %b", m_cyc,
                         digits, seg, dp, busy, exp_digits, exp_seg, exp_dp, exp_busy);
            end
        end
    endtask

    task automatic test_scan();
        input_value = 16'hABCD;
        start_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        repeat (3 * N * SLOT) begin
            tick();
            n_checks++;
            if ({digits, seg, dp, busy} !== {exp_digits, exp_seg, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL scan cyc=%0d: got %b %b %b %b want %b %b %b %b", m_cyc,
                         digits, seg, dp, busy, exp_digits, exp_seg, exp_dp, exp_busy);
            end
        end
    endtask

    task automatic test_frame_sync();
        int guard;
        guard = 0;
        while (!(((m_cyc / SLOT) % N == 1) && (m_cyc % SLOT == 8)) && guard < 200) begin
            tick();
            guard++;
        end
        n_checks++;
        if (guard >= 200) begin
            n_fail++;
            $display("FAIL frame_sync_align: waited %0d cycles, want < 200", guard);
        end
        input_value = 16'h1234;
        repeat (2 * N * SLOT + 10) begin
            tick();
            n_checks++;
            if ({digits, seg, dp, busy} !== {exp_digits, exp_seg, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL frame_sync cyc=%0d: got %b %b %b %b want %b %b %b %b", m_cyc,
                         digits, seg, dp, busy, exp_digits, exp_seg, exp_dp, exp_busy);
            end
        end
    endtask

    task automatic test_lz_blank();
        logic [4*N-1:0] vals [2];
        vals[0] = 16'h0040;
        vals[1] = 16'h0000;
        lz_blank = 1'b1;
        for (int v = 0; v < 2; v++) begin
            input_value = vals[v];
            repeat (3 * N * SLOT) begin
                tick();
                n_checks++;
                if ({digits, seg, dp, busy} !== {exp_digits, exp_seg, exp_dp, exp_busy}) begin
                    n_fail++;
                    $display("FAIL lz_blank val=%h cyc=%0d: got %b %b %b %b want %b %b %b %b",
                             vals[v], m_cyc, digits, seg, dp, busy,
                             exp_digits, exp_seg, exp_dp, exp_busy);
                end
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_blink();
        input_value = 16'h5A0F;
        dp_in = 4'b0100;
        blink_en = 1'b1;
        repeat (600) begin
            tick();
            n_checks++;
            if ({digits, seg, dp, busy} !== {exp_digits, exp_seg, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL blink cyc=%0d: got %b %b %b %b want %b %b %b %b", m_cyc,
                         digits, seg, dp, busy, exp_digits, exp_seg, exp_dp, exp_busy);
            end
        end
        blink_en = 1'b0;
        dp_in = '0;
    endtask

    task automatic test_start_stop();
        start_signal = 1'b1;
        stop_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        stop_signal = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_stop_busy: busy=%b, want 0", busy);
        end
        repeat (30) tick();
        start_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        repeat (37) tick();
        input_value = 16'hE7C9;
        start_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        repeat (2 * N * SLOT) begin
            tick();
            n_checks++;
            if ({digits, seg, dp, busy} !== {exp_digits, exp_seg, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL reload_in_show cyc=%0d: got %b %b %b %b want %b %b %b %b", m_cyc,
                         digits, seg, dp, busy, exp_digits, exp_seg, exp_dp, exp_busy);
            end
        end
    endtask

    task automatic test_random();
        repeat (1500) begin
            if ($urandom_range(7, 0) == 0) input_value = 16'($urandom);
            if ($urandom_range(15, 0) == 0) input_value = 16'($urandom_range(255, 0));
            dp_in = 4'($urandom);
            if ($urandom_range(15, 0) == 0) lz_blank = ~lz_blank;
            if ($urandom_range(63, 0) == 0) blink_en = ~blink_en;
            start_signal = ($urandom_range(39, 0) == 0);
            stop_signal  = ($urandom_range(59, 0) == 0);
            tick();
            n_checks++;
            if ({digits, seg, dp, busy} !== {exp_digits, exp_seg, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL random cyc=%0d: got %b %b %b %b want %b %b %b %b", m_cyc,
                         digits, seg, dp, busy, exp_digits, exp_seg, exp_dp, exp_busy);
            end
        end
        start_signal = 1'b0;
        stop_signal = 1'b0;
        lz_blank = 1'b0;
        blink_en = 1'b0;
    endtask

    task automatic test_mid_scan_reset();
        input_value = 16'h9F31;
        start_signal = 1'b1;
        tick();
        start_signal = 1'b0;
        repeat (41) tick();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({digits, seg, dp, busy} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_scan_reset: digits=%b seg=%b dp=%b busy=%b, want 1111 1111111 1 0",
                     digits, seg, dp, busy);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (80) begin
            tick();
            n_checks++;
            if ({digits, seg, dp, busy} !== {exp_digits, exp_seg, exp_dp, exp_busy}) begin
                n_fail++;
                $display("FAIL after_mid_reset cyc=%0d: got %b %b %b %b want %b %b %b %b", m_cyc,
                         digits, seg, dp, busy, exp_digits, exp_seg, exp_dp, exp_busy);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan();
        test_frame_sync();
        test_lz_blank();
        test_blink();
        test_start_stop();
        test_random();
        test_mid_scan_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
